// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined CLA adder: configuration check and stage count.
package cla_pkg;

    // True when the operand width splits evenly into whole chunks.
    function automatic bit chunk_fits(input int nbit, input int chunk);
        return (chunk > 0) && (nbit >= chunk) && ((nbit % chunk) == 0);
    endfunction

    // Number of pipeline stages (one chunk per stage); also the latency in cycles.
    function automatic int stage_count(input int nbit, input int chunk);
        return (chunk > 0) ? (nbit / chunk) : 1;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational W-bit carry-lookahead slice. Every internal carry is a
// flat sum-of-products of generate/propagate terms, so there is no ripple.
module cla_chunk #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries: c[i] = OR over j of g[j] & p[j+1..i-1], plus c_in & p[0..i-1].
    always_comb begin
        logic acc;
        logic run;
        acc  = 1'b0;
        run  = 1'b1;
        c    = '0;
        c[0] = c_in;
        for (int i = 1; i <= W; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & run);
                run = run & p[j];
            end
            c[i] = acc | (c_in & run);
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign c_out = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Chunk k is summed in stage k;
// operand chunks are skewed forward to meet their carry, finished low chunks
// are deskewed so the full result leaves in one cycle. The whole pipe moves
// only when the output slot is free or being consumed.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int NBIT  = 28,
    parameter int CHUNK = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT:0]   s,
    output logic            ovf
);

    localparam int NSTAGE = stage_count(NBIT, CHUNK);

    if (!chunk_fits(NBIT, CHUNK)) begin : g_bad_cfg
        $error("pipe_cla_adder: NBIT must be a non-zero multiple of CHUNK");
    end

    logic                         advance;
    logic [NSTAGE-1:0]            vld_pipe;   // vld_pipe[k]: stage k holds a live op
    logic [NBIT-1:0]              b_eff;
    logic                         c0;
    logic [NSTAGE-1:0]            carry_vec;  // registered carry-out of each stage
    logic [NSTAGE-1:0][CHUNK-1:0] res;        // deskewed chunk results, aligned in time
    logic                         ovf_d;
    logic                         ovf_q;

    assign out_valid = vld_pipe[NSTAGE-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    // Subtract is a + ~b + 1; a borrow-in removes that +1.
    assign b_eff = sub ? ~b : b;
    assign c0    = c_in ^ sub;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic             cin;
        logic [CHUNK-1:0] sum;
        logic             c_out;
        logic             c_msb;
        logic [CHUNK-1:0] sum_q;
        logic             carry_q;

        if (k == 0) begin : g_head
            assign op_a = a[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
            assign cin  = c0;
        end else begin : g_skew
            logic [k-1:0][CHUNK-1:0] a_dly;
            logic [k-1:0][CHUNK-1:0] b_dly;

            // Delay this chunk's operands k cycles so they meet the carry from stage k-1.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_dly <= '0;
                    b_dly <= '0;
                end else if (advance) begin
                    a_dly[0] <= a[k*CHUNK +: CHUNK];
                    b_dly[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int d = 1; d < k; d++) begin
                        a_dly[d] <= a_dly[d-1];
                        b_dly[d] <= b_dly[d-1];
                    end
                end
            end

            assign op_a = a_dly[k-1];
            assign op_b = b_dly[k-1];
            assign cin  = carry_vec[k-1];
        end

        cla_chunk #(.W(CHUNK)) u_chunk (
            .a     (op_a),
            .b     (op_b),
            .c_in  (cin),
            .sum   (sum),
            .c_out (c_out),
            .c_msb (c_msb)
        );

        // Stage register: this chunk's partial sum and the carry handed to stage k+1.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (advance) begin
                sum_q   <= sum;
                carry_q <= c_out;
            end
        end

        assign carry_vec[k] = carry_q;

        if (k == NSTAGE - 1) begin : g_tail
            assign res[k] = sum_q;
            // Signed overflow: carry into the word MSB differs from carry out of it.
            assign ovf_d  = c_msb ^ c_out;
        end else begin : g_deskew
            logic                             msb_unused;
            logic [NSTAGE-2-k:0][CHUNK-1:0]   r_dly;

            assign msb_unused = c_msb;

            // Hold finished low chunk until the top chunk catches up.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else if (advance) begin
                    r_dly[0] <= sum_q;
                    for (int d = 1; d <= NSTAGE - 2 - k; d++) begin
                        r_dly[d] <= r_dly[d-1];
                    end
                end
            end

            assign res[k] = r_dly[NSTAGE-2-k];
        end
    end

    // Valid shift register and overflow flag; frozen together with the data on a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ovf_q    <= 1'b0;
        end else if (advance) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k < NSTAGE; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            ovf_q <= ovf_d;
        end
    end

    assign s   = {carry_vec[NSTAGE-1], res};
    assign ovf = ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (NBIT=28, CHUNK=7, 4 stages).
module tb_pipe_cla_adder;

    localparam int NBIT   = 28;
    localparam int CHUNK  = 7;
    localparam int NSTAGE = NBIT / CHUNK;

    typedef struct {
        logic [NBIT:0] s;
        logic          ovf;
        int            acc_cyc;
        bit            lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NBIT-1:0] a = '0;
    logic [NBIT-1:0] b = '0;
    logic            c_in = 1'b0;
    logic            sub = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [NBIT:0]   s;
    logic            ovf;

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    pipe_cla_adder #(.NBIT(NBIT), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [NBIT-1:0] ia, input logic [NBIT-1:0] ib,
                                   input logic icin, input logic isub);
        exp_t            e;
        logic [NBIT-1:0] bb;
        bb      = isub ? ~ib : ib;
        e.s     = {1'b0, ia} + {1'b0, bb} + {{NBIT{1'b0}}, icin ^ isub};
        e.ovf   = (ia[NBIT-1] == bb[NBIT-1]) && (e.s[NBIT-1] != ia[NBIT-1]);
        e.acc_cyc = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    // Present one op and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [NBIT-1:0] ia, input logic [NBIT-1:0] ib,
                        input logic icin, input logic isub, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        a = ia; b = ib; c_in = icin; sub = isub; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #2;
            if (in_ready) begin
                e = model(ia, ib, icin, isub);
                e.acc_cyc = cyc;
                e.lat = lat;
                sb.push_back(e);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: every output transfer must match the oldest expected op.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("s", 64'(s), 64'(e.s));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                    if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(NSTAGE));
                end
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        // Basic add with latency check
        send(28'd2, 28'd3, 1'b0, 1'b0, 1'b1);
        idle();
        drain();

        // Directed corners: full carry ripple, subtract both signs, signed overflow
        send(28'hFFFFFFF, 28'd1, 1'b0, 1'b0, 1'b0);
        send(28'd5, 28'd10, 1'b0, 1'b1, 1'b0);
        send(28'd10, 28'd5, 1'b0, 1'b1, 1'b0);
        send(28'h7FFFFFF, 28'd1, 1'b0, 1'b0, 1'b0);
        send(28'h8000000, 28'h8000000, 1'b0, 1'b0, 1'b0);
        send(28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 1'b0, 1'b0);
        send(28'd0, 28'd0, 1'b1, 1'b1, 1'b0);
        idle();
        drain();

        // Backpressure: stall 3 cycles once the first result appears
        fork
            begin
                for (int i = 1; i <= 6; i++) send(28'(i), 28'd100, 1'b0, 1'b0, 1'b0);
                idle();
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_rise", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #2;
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_s_hold", 64'(s), 64'd101);
                    chk("bp_valid_hold", 64'(out_valid), 64'd1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random ops with occasional bubbles
        for (int i = 0; i < 24; i++) begin
            send(28'($urandom), 28'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        // Reset with ops in flight: nothing may emerge afterwards
        send(28'd11, 28'd1, 1'b0, 1'b0, 1'b0);
        send(28'd12, 28'd1, 1'b0, 1'b0, 1'b0);
        send(28'd13, 28'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_s", 64'(s), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("mrst_quiet", 64'(out_valid), 64'd0);
        end
        chk("mrst_in_ready_end", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
